privacy_noise_scheduler: RTL and testbench



---
 rtl/privacy_noise_scheduler.sv | 128 ++++++++++++
 tb/tb_privacy_noise_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/privacy_noise_scheduler.sv
// Sequences one CNN inference per query and hands true/noisy class plus the noise decision to the privacy stage.
// Optional secure-mode query budget is compiled in when PRIVACY_BUDGET_EN is defined.
module privacy_noise_scheduler #(
  parameter int          NUM_CLASSES = 10,
  parameter int          NOISE_RATE  = 64,
  parameter int          BUDGET      = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       secure_mode_active,
  input  logic       query_req,
  output logic       query_ack,
  output logic       cnn_start,
  input  logic       cnn_done,
  input  logic [3:0] cnn_class,
  output logic       inject_noise,
  output logic [3:0] class_noisy,
  output logic [3:0] class_true,
  output logic       done_to_priv,
  input  logic       budget_reload,
  output logic [7:0] budget_left,
  output logic       locked
);

  typedef enum logic [1:0] {IDLE, RUN, DECIDE, ISSUE} state_t;

  localparam logic [4:0] NC      = 5'(NUM_CLASSES);
  localparam logic [3:0] NC_M1   = 4'(NUM_CLASSES - 1);
  localparam logic [8:0] RATE    = 9'(NOISE_RATE);

  state_t      state_reg, state_next;
  logic [15:0] lfsr_reg, lfsr_next;
  logic [3:0]  class_true_reg;
  logic [3:0]  class_noisy_reg;
  logic        inject_noise_reg;
  logic [3:0]  offset;
  logic [4:0]  noisy_sum;
  logic [3:0]  class_noisy_next;
  logic        inject_next;

  // Galois form of x^16+x^14+x^13+x^11
  assign lfsr_next = lfsr_reg[0] ? ({1'b0, lfsr_reg[15:1]} ^ 16'hB400) : {1'b0, lfsr_reg[15:1]};

  // Offset in 1..NUM_CLASSES-1 guarantees the substitute differs from the true class
  assign offset           = lfsr_reg[11:8] % NC_M1;
  assign noisy_sum        = {1'b0, class_true_reg} + 5'd1 + {1'b0, offset};
  assign class_noisy_next = 4'(noisy_sum % NC);
  assign inject_next      = secure_mode_active && ({1'b0, lfsr_reg[7:0]} < RATE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= IDLE;
      lfsr_reg         <= LFSR_SEED;
      class_true_reg   <= 4'd0;
      class_noisy_reg  <= 4'd0;
      inject_noise_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      if (state_reg == RUN && cnn_done) begin
        class_true_reg <= cnn_class;
      end
      if (state_reg == DECIDE) begin
        class_noisy_reg  <= class_noisy_next;
        inject_noise_reg <= inject_next;
      end
    end
  end

`ifdef PRIVACY_BUDGET_EN
  logic [7:0] budget_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      budget_reg <= 8'(BUDGET);
    end else if (budget_reload) begin
      budget_reg <= 8'(BUDGET);
    end else if (state_reg == ISSUE && secure_mode_active && budget_reg != 8'd0) begin
      budget_reg <= budget_reg - 8'd1;
    end
  end

  assign budget_left = budget_reg;
  assign locked      = secure_mode_active && (budget_reg == 8'd0);
`else
  logic unused_budget_reload;
  assign unused_budget_reload = budget_reload;
  assign budget_left          = 8'd0;
  assign locked               = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    query_ack    = 1'b0;
    cnn_start    = 1'b0;
    done_to_priv = 1'b0;
    case (state_reg)
      IDLE: begin
        if (query_req && !locked) begin
          query_ack  = 1'b1;
          cnn_start  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnn_done) begin
          state_next = DECIDE;
        end
      end
      DECIDE: begin
        state_next = ISSUE;
      end
      ISSUE: begin
        done_to_priv = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign class_true   = class_true_reg;
  assign class_noisy  = class_noisy_reg;
  assign inject_noise = inject_noise_reg;

endmodule

// File: tb/tb_privacy_noise_scheduler.sv
// Randomized self-checking bench for privacy_noise_scheduler; three instances share stimulus
// and differ only in NOISE_RATE (64, 256, 0) so one run covers normal, always and never noise.
module tb_privacy_noise_scheduler;
  localparam int NC  = 10;
  localparam int BUD = 4;
`ifdef PRIVACY_BUDGET_EN
  localparam bit BUD_EN = 1'b1;
`else
  localparam bit BUD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       secure_mode_active = 1'b0;
  logic       query_req = 1'b0;
  logic       cnn_done = 1'b0;
  logic [3:0] cnn_class = 4'd0;
  logic       budget_reload = 1'b0;

  logic       query_ack, cnn_start, inject_noise, done_to_priv, locked;
  logic [3:0] class_noisy, class_true;
  logic [7:0] budget_left;
  logic       ack_h, start_h, inj_h, done_h, locked_h;
  logic [3:0] noisy_h, true_h;
  logic [7:0] budget_h;
  logic       ack_z, start_z, inj_z, done_z, locked_z;
  logic [3:0] noisy_z, true_z;
  logic [7:0] budget_z;

  int errors = 0;
  int checks = 0;
  int exp_budget;
  logic [15:0] m_lfsr;

  privacy_noise_scheduler #(.NUM_CLASSES(NC), .NOISE_RATE(64), .BUDGET(BUD), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .resetn(resetn), .secure_mode_active(secure_mode_active), .query_req(query_req),
    .query_ack(query_ack), .cnn_start(cnn_start), .cnn_done(cnn_done), .cnn_class(cnn_class),
    .inject_noise(inject_noise), .class_noisy(class_noisy), .class_true(class_true),
    .done_to_priv(done_to_priv), .budget_reload(budget_reload), .budget_left(budget_left), .locked(locked));

  privacy_noise_scheduler #(.NUM_CLASSES(NC), .NOISE_RATE(256), .BUDGET(BUD), .LFSR_SEED(16'hACE1)) dut_h (
    .clk(clk), .resetn(resetn), .secure_mode_active(secure_mode_active), .query_req(query_req),
    .query_ack(ack_h), .cnn_start(start_h), .cnn_done(cnn_done), .cnn_class(cnn_class),
    .inject_noise(inj_h), .class_noisy(noisy_h), .class_true(true_h),
    .done_to_priv(done_h), .budget_reload(budget_reload), .budget_left(budget_h), .locked(locked_h));

  privacy_noise_scheduler #(.NUM_CLASSES(NC), .NOISE_RATE(0), .BUDGET(BUD), .LFSR_SEED(16'hACE1)) dut_z (
    .clk(clk), .resetn(resetn), .secure_mode_active(secure_mode_active), .query_req(query_req),
    .query_ack(ack_z), .cnn_start(start_z), .cnn_done(cnn_done), .cnn_class(cnn_class),
    .inject_noise(inj_z), .class_noisy(noisy_z), .class_true(true_z),
    .done_to_priv(done_z), .budget_reload(budget_reload), .budget_left(budget_z), .locked(locked_z));

  always #5 clk = ~clk;

  // Reference pseudo-random sequence: polynomial x^16+x^14+x^13+x^11, one step per clock
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic bit exp_locked();
    return BUD_EN && secure_mode_active && (exp_budget == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete query; cnn_done arrives after 'delay' idle RUN cycles
  task automatic do_query(input logic [3:0] cls, input int delay, input bit rl_issue, input string tag);
    logic [15:0] l;
    int exp_noisy;
    bit exp_inj;
    bit rl_now;
    query_req = 1'b1;
    #1;
    checks++;
    if (query_ack !== 1'b1 || cnn_start !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: ack=%b start=%b required 1/1", tag, query_ack, cnn_start);
    end
    tick();
    query_req = 1'b0;
    #1;
    checks++;
    if (query_ack !== 1'b0 || cnn_start !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: ack=%b start=%b required 0/0", tag, query_ack, cnn_start);
    end
    repeat (delay) tick();
    cnn_done  = 1'b1;
    cnn_class = cls;
    tick();
    cnn_done  = 1'b0;
    cnn_class = 4'($urandom_range(0, 15));
    l = m_lfsr;
    exp_noisy = (int'(cls) + 1 + (int'(l[11:8]) % (NC - 1))) % NC;
    exp_inj   = secure_mode_active && (int'(l[7:0]) < 64);
    tick();
    rl_now = budget_reload | rl_issue;
    budget_reload = rl_now;
    #1;
    checks++;
    if (done_to_priv !== 1'b1 || class_true !== cls || class_noisy !== 4'(exp_noisy) || inject_noise !== exp_inj) begin
      errors++;
      $display("FAIL %s result: done=%b true=%0d noisy=%0d inj=%b required 1/%0d/%0d/%b",
               tag, done_to_priv, class_true, class_noisy, inject_noise, cls, exp_noisy, exp_inj);
    end
    checks++;
    if (inj_h !== secure_mode_active || inj_z !== 1'b0 || noisy_h !== 4'(exp_noisy) ||
        noisy_h == cls || int'(noisy_h) >= NC) begin
      errors++;
      $display("FAIL %s rate_extremes: inj256=%b inj0=%b noisy=%0d required %b/0/%0d (true=%0d)",
               tag, inj_h, inj_z, noisy_h, secure_mode_active, exp_noisy, cls);
    end
    if (BUD_EN) begin
      if (rl_now) exp_budget = BUD;
      else if (secure_mode_active && exp_budget > 0) exp_budget--;
    end
    tick();
    if (rl_issue) budget_reload = 1'b0;
    #1;
    checks++;
    if (done_to_priv !== 1'b0 || budget_left !== 8'(exp_budget) || locked !== exp_locked()) begin
      errors++;
      $display("FAIL %s after: done=%b budget=%0d locked=%b required 0/%0d/%b",
               tag, done_to_priv, budget_left, locked, exp_budget, exp_locked());
    end
    $display("query %s cls=%0d sec=%b noisy=%0d inj=%b budget=%0d", tag, cls, secure_mode_active,
             class_noisy, inject_noise, budget_left);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (query_ack !== 1'b0 || cnn_start !== 1'b0 || inject_noise !== 1'b0 || class_noisy !== 4'd0 ||
        class_true !== 4'd0 || done_to_priv !== 1'b0 || budget_left !== 8'(exp_budget) || locked !== exp_locked()) begin
      errors++;
      $display("FAIL %s reset_values: ack=%b start=%b inj=%b noisy=%0d true=%0d done=%b budget=%0d locked=%b required 0/0/0/0/0/0/%0d/%b",
               tag, query_ack, cnn_start, inject_noise, class_noisy, class_true, done_to_priv,
               budget_left, locked, exp_budget, exp_locked());
    end
  endtask

  task automatic test_reset();
    exp_budget = BUD_EN ? BUD : 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_nonsecure();
    secure_mode_active = 1'b0;
    do_query(4'd3, 1, 1'b0, "nonsecure");
  endtask

  task automatic test_noise();
    secure_mode_active = 1'b1;
    budget_reload = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      do_query(4'($urandom_range(0, NC - 1)), int'($urandom_range(0, 2)), 1'b0, "noise");
    end
    budget_reload = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    secure_mode_active = 1'b0;
    query_req = 1'b1;
    #1;
    checks++;
    if (query_ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b first_ack: ack=%b required 1", query_ack);
    end
    tick();
    cnn_done  = 1'b1;
    cnn_class = 4'd7;
    #1;
    checks++;
    if (query_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b ack_in_run: ack=%b required 0", query_ack);
    end
    tick();
    cnn_done = 1'b0;
    #1;
    checks++;
    if (query_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b ack_in_decide: ack=%b required 0", query_ack);
    end
    tick();
    #1;
    checks++;
    if (query_ack !== 1'b0 || done_to_priv !== 1'b1 || class_true !== 4'd7) begin
      errors++;
      $display("FAIL b2b issue: ack=%b done=%b true=%0d required 0/1/7", query_ack, done_to_priv, class_true);
    end
    tick();
    $display("query b2b first done, second query pending");
    do_query(4'd0, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_midrun();
    secure_mode_active = 1'b0;
    query_req = 1'b1;
    tick();
    query_req = 1'b0;
    tick();
    resetn = 1'b0;
    exp_budget = BUD_EN ? BUD : 0;
    #1;
    check_reset_values("midrun");
    tick();
    resetn = 1'b1;
    tick();
    cnn_done  = 1'b1;
    cnn_class = 4'd5;
    tick();
    cnn_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done_to_priv !== 1'b0 || class_true !== 4'd0) begin
        errors++;
        $display("FAIL midrun stray_done cycle %0d: done=%b true=%0d required 0/0", i, done_to_priv, class_true);
      end
      tick();
    end
    do_query(4'd9, 2, 1'b0, "post_reset");
  endtask

`ifdef PRIVACY_BUDGET_EN
  task automatic test_lockout();
    secure_mode_active = 1'b1;
    for (int i = 0; i < BUD; i++) do_query(4'($urandom_range(0, NC - 1)), 0, 1'b0, "lockout");
    checks++;
    if (budget_left !== 8'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL lockout exhausted: budget=%0d locked=%b required 0/1", budget_left, locked);
    end
    query_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (query_ack !== 1'b0 || cnn_start !== 1'b0) begin
        errors++;
        $display("FAIL lockout blocked cycle %0d: ack=%b start=%b required 0/0", i, query_ack, cnn_start);
      end
      tick();
    end
    budget_reload = 1'b1;
    tick();
    budget_reload = 1'b0;
    exp_budget = BUD;
    checks++;
    if (budget_left !== 8'(BUD) || locked !== 1'b0) begin
      errors++;
      $display("FAIL lockout reload: budget=%0d locked=%b required %0d/0", budget_left, locked, BUD);
    end
    do_query(4'd2, 1, 1'b0, "fifth");
    do_query(4'd8, 0, 1'b0, "sixth");
  endtask

  task automatic test_reload_vs_dec();
    secure_mode_active = 1'b1;
    checks++;
    if (budget_left !== 8'd2) begin
      errors++;
      $display("FAIL reload_vs_dec precondition: budget=%0d required 2", budget_left);
    end
    do_query(4'd4, 0, 1'b1, "reload_in_issue");
  endtask
`else
  task automatic test_macro_off();
    secure_mode_active = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_query(4'($urandom_range(0, NC - 1)), int'($urandom_range(0, 1)), 1'b0, "macro_off");
    end
    checks++;
    if (budget_left !== 8'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL macro_off final: budget=%0d locked=%b required 0/0", budget_left, locked);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nonsecure();
    test_noise();
    test_back_to_back();
`ifdef PRIVACY_BUDGET_EN
    test_lockout();
    test_reload_vs_dec();
`else
    test_macro_off();
`endif
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
